// File: rtl/os_systolic_array_if.sv
// Host-side bundle for the output-stationary MAC grid: control strobes,
// skewed west/north operands and the drained per-row partial sums.
interface os_systolic_array_if #(
    parameter int DATA_WIDTH = 8,
    parameter int S_WIDTH    = 2,
    parameter int S_HEIGHT   = 2
);
    // Handshake: no valid/ready; every control strobe and operand is
    // sampled on each rising edge and o_ifmap is combinational from state.
    logic                                     i_reg_clear;
    logic                                     i_pe_en;
    logic                                     i_relu_en;
    logic                                     i_psum_out_en;
    logic [0:S_HEIGHT-1][DATA_WIDTH-1:0]      i_ifmap;
    logic [0:S_WIDTH-1][DATA_WIDTH-1:0]       i_weight;
    logic [0:S_HEIGHT-1][2*DATA_WIDTH-1:0]    o_ifmap;

    modport master (
        output i_reg_clear, i_pe_en, i_relu_en, i_psum_out_en, i_ifmap, i_weight,
        input  o_ifmap
    );

    modport slave (
        input  i_reg_clear, i_pe_en, i_relu_en, i_psum_out_en, i_ifmap, i_weight,
        output o_ifmap
    );
endinterface

// File: rtl/os_systolic_array.sv
// Output-stationary S_HEIGHT x S_WIDTH signed MAC grid: ifmaps shift east,
// weights shift south, each PE keeps its own accumulator, results drain east.
module os_systolic_array #(
    parameter int DATA_WIDTH = 8,
    parameter int S_WIDTH    = 2,
    parameter int S_HEIGHT   = 2
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    os_systolic_array_if.slave bus
);
    localparam int PW = 2 * DATA_WIDTH;

    // Neighbour taps: each PE publishes its registers here for east/south use.
    logic [DATA_WIDTH-1:0] a_w [S_HEIGHT][S_WIDTH];
    logic [DATA_WIDTH-1:0] b_w [S_HEIGHT][S_WIDTH];
    logic [PW-1:0]         p_w [S_HEIGHT][S_WIDTH];

    for (genvar r = 0; r < S_HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < S_WIDTH; c++) begin : g_pe
            logic [DATA_WIDTH-1:0] ain;
            logic [DATA_WIDTH-1:0] bin;
            logic [PW-1:0]         p_west;
            logic [PW-1:0]         ain_x;
            logic [PW-1:0]         bin_x;
            logic [PW-1:0]         prod;
            logic [DATA_WIDTH-1:0] a_q, a_d;
            logic [DATA_WIDTH-1:0] b_q, b_d;
            logic [PW-1:0]         p_q, p_d;

            if (c == 0) begin : g_west_edge
                assign ain    = bus.i_ifmap[r];
                assign p_west = '0;
            end else begin : g_west_pe
                assign ain    = a_w[r][c-1];
                assign p_west = p_w[r][c-1];
            end

            if (r == 0) begin : g_north_edge
                assign bin = bus.i_weight[c];
            end else begin : g_north_pe
                assign bin = b_w[r-1][c];
            end

            // Sign-extend first so the low PW bits of the product are the
            // exact two's-complement result; the accumulator wraps mod 2^PW.
            assign ain_x = {{DATA_WIDTH{ain[DATA_WIDTH-1]}}, ain};
            assign bin_x = {{DATA_WIDTH{bin[DATA_WIDTH-1]}}, bin};
            assign prod  = ain_x * bin_x;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                p_d = p_q;
                if (bus.i_reg_clear) begin
                    a_d = '0;
                    b_d = '0;
                    p_d = '0;
                end else if (bus.i_psum_out_en) begin
                    p_d = p_west;
                end else if (bus.i_pe_en) begin
                    a_d = ain;
                    b_d = bin;
                    p_d = p_q + prod;
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_nrst) begin
                    a_q <= '0;
                    b_q <= '0;
                    p_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                    p_q <= p_d;
                end
            end

            assign a_w[r][c] = a_q;
            assign b_w[r][c] = b_q;
            assign p_w[r][c] = p_q;
        end
    end

    // The east-most accumulator of each row is what the drain presents.
    always_comb begin
        bus.o_ifmap = '0;
        for (int r = 0; r < S_HEIGHT; r++) begin
            if (bus.i_psum_out_en) begin
                if (bus.i_relu_en && p_w[r][S_WIDTH-1][PW-1]) begin
                    bus.o_ifmap[r] = '0;
                end else begin
                    bus.o_ifmap[r] = p_w[r][S_WIDTH-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_os_systolic_array.sv
// Self-checking bench for os_systolic_array: directed matmul/ReLU/overflow
// cases plus randomized matrices checked against a plain matrix-product model.
module tb_os_systolic_array;
    localparam int DW   = 8;
    localparam int SW   = 2;
    localparam int SH   = 2;
    localparam int PW   = 2 * DW;
    localparam int MAXK = 8;

    logic clk = 1'b0;
    logic nrst;

    always #5 clk = ~clk;

    os_systolic_array_if #(.DATA_WIDTH(DW), .S_WIDTH(SW), .S_HEIGHT(SH)) bus ();

    os_systolic_array #(.DATA_WIDTH(DW), .S_WIDTH(SW), .S_HEIGHT(SH)) dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference operands: A is SH x K, B is K x SW, C = A*B mod 2^PW.
    int            a_m [SH][MAXK];
    int            b_m [MAXK][SW];
    int            k_len;
    logic [PW-1:0] c_m [SH][SW];
    logic [PW-1:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] relu_f(input logic [PW-1:0] x, input bit en);
        return (en && x[PW-1]) ? '0 : x;
    endfunction

    task automatic idle_inputs();
        bus.i_reg_clear   = 1'b0;
        bus.i_pe_en       = 1'b0;
        bus.i_relu_en     = 1'b0;
        bus.i_psum_out_en = 1'b0;
        bus.i_ifmap       = '0;
        bus.i_weight      = '0;
    endtask

    task automatic clear_grid();
        bus.i_reg_clear = 1'b1;
        tick();
        bus.i_reg_clear = 1'b0;
    endtask

    task automatic compute_model();
        for (int r = 0; r < SH; r++) begin
            for (int c = 0; c < SW; c++) begin
                int acc;
                acc = 0;
                for (int k = 0; k < k_len; k++) acc += a_m[r][k] * b_m[k][c];
                c_m[r][c] = acc[PW-1:0];
            end
        end
    endtask

    // Present enable cycle t of the skewed operand schedule.
    task automatic drive_skew(input int t);
        for (int r = 0; r < SH; r++) begin
            int k;
            int v;
            k = t - r;
            v = (k >= 0 && k < k_len) ? a_m[r][k] : 0;
            bus.i_ifmap[r] = v[DW-1:0];
        end
        for (int c = 0; c < SW; c++) begin
            int k;
            int v;
            k = t - c;
            v = (k >= 0 && k < k_len) ? b_m[k][c] : 0;
            bus.i_weight[c] = v[DW-1:0];
        end
    endtask

    task automatic run_compute(input int stall_pct);
        for (int t = 0; t < k_len + SH + SW - 2; t++) begin
            drive_skew(t);
            bus.i_pe_en = 1'b1;
            tick();
            for (int s = 0; s < 3; s++) begin
                if ($urandom_range(99) < stall_pct) begin
                    bus.i_pe_en = 1'b0;
                    tick();
                end
            end
        end
        bus.i_pe_en  = 1'b0;
        bus.i_ifmap  = '0;
        bus.i_weight = '0;
    endtask

    // Drain SW+1 cycles with junk operands and a random i_pe_en, which must
    // neither accumulate nor disturb the drain order.
    task automatic drain_check(input string tag, input bit relu, input bit zero_exp);
        exp_q.delete();
        for (int d = 0; d <= SW; d++) begin
            for (int r = 0; r < SH; r++) begin
                if (zero_exp || d == SW) exp_q.push_back('0);
                else exp_q.push_back(relu_f(c_m[r][SW-1-d], relu));
            end
        end
        for (int d = 0; d <= SW; d++) begin
            bus.i_psum_out_en = 1'b1;
            bus.i_relu_en     = relu;
            bus.i_pe_en       = 1'($urandom_range(1));
            for (int r = 0; r < SH; r++) bus.i_ifmap[r] = DW'($urandom);
            for (int c = 0; c < SW; c++) bus.i_weight[c] = DW'($urandom);
            #1;
            for (int r = 0; r < SH; r++) begin
                check_eq($sformatf("%s_d%0d_r%0d", tag, d, r), 32'(bus.o_ifmap[r]), 32'(exp_q.pop_front()));
            end
            tick();
        end
        idle_inputs();
        #1;
        for (int r = 0; r < SH; r++) begin
            check_eq($sformatf("%s_off_r%0d", tag, r), 32'(bus.o_ifmap[r]), 32'd0);
        end
    endtask

    task automatic zero_mats();
        for (int r = 0; r < SH; r++) for (int k = 0; k < MAXK; k++) a_m[r][k] = 0;
        for (int k = 0; k < MAXK; k++) for (int c = 0; c < SW; c++) b_m[k][c] = 0;
    endtask

    task automatic load_2x2();
        zero_mats();
        k_len = 2;
        a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
        b_m[0][0] = 1; b_m[0][1] = 2; b_m[1][0] = 3; b_m[1][1] = 4;
        compute_model();
    endtask

    task automatic load_random();
        zero_mats();
        k_len = $urandom_range(MAXK, 1);
        for (int r = 0; r < SH; r++)
            for (int k = 0; k < k_len; k++) a_m[r][k] = int'($urandom_range(255)) - 128;
        for (int k = 0; k < k_len; k++)
            for (int c = 0; c < SW; c++) b_m[k][c] = int'($urandom_range(255)) - 128;
        compute_model();
    endtask

    initial begin
        idle_inputs();
        nrst = 1'b1;
        bus.i_psum_out_en = 1'b1;
        tick();
        for (int r = 0; r < SH; r++) begin
            check_eq($sformatf("rst_out_r%0d", r), 32'(bus.o_ifmap[r]), 32'd0);
        end
        check_eq("rst_no_x", 32'($isunknown(bus.o_ifmap)), 32'd0);
        nrst = 1'b0;
        bus.i_psum_out_en = 1'b0;
        tick();

        load_2x2();
        run_compute(0);
        drain_check("mm2x2", 1'b0, 1'b0);

        clear_grid();
        load_2x2();
        run_compute(0);
        clear_grid();
        drain_check("clear", 1'b0, 1'b1);

        clear_grid();
        load_2x2();
        run_compute(60);
        drain_check("stall", 1'b0, 1'b0);

        for (int relu = 0; relu < 2; relu++) begin
            clear_grid();
            zero_mats();
            k_len = 1;
            a_m[0][0] = -3;
            b_m[0][0] = 2;
            compute_model();
            run_compute(0);
            drain_check($sformatf("signed_relu%0d", relu), 1'(relu), 1'b0);
        end

        clear_grid();
        zero_mats();
        k_len = 5;
        for (int k = 0; k < 5; k++) begin
            a_m[0][k] = 127;
            b_m[k][0] = 127;
        end
        compute_model();
        run_compute(0);
        drain_check("overflow", 1'b0, 1'b0);

        // All enables low with junk operands: accumulators must hold.
        clear_grid();
        load_random();
        run_compute(0);
        for (int i = 0; i < 3; i++) begin
            bus.i_ifmap  = {SH{DW'($urandom)}};
            bus.i_weight = {SW{DW'($urandom)}};
            tick();
        end
        idle_inputs();
        drain_check("hold", 1'b0, 1'b0);

        // Reset during a partial drain discards everything.
        clear_grid();
        load_2x2();
        run_compute(0);
        bus.i_psum_out_en = 1'b1;
        tick();
        nrst = 1'b1;
        tick();
        nrst = 1'b0;
        idle_inputs();
        drain_check("rst_mid", 1'b0, 1'b1);

        for (int it = 0; it < 20; it++) begin
            bit relu;
            relu = 1'($urandom_range(1));
            if ($urandom_range(3) == 0) begin
                nrst = 1'b1;
                tick();
                nrst = 1'b0;
            end else begin
                clear_grid();
            end
            load_random();
            run_compute(25);
            drain_check($sformatf("rand%0d", it), relu, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
